mips_mem_port_arbiter: RTL and testbench
========================================

// Module: mips_mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the pipeline's IF port and MEM-stage data port (LW/SW).
//  Sits between the pipe_MIPS32 stages and the memory array; one transaction in flight at a time.
//  Default policy: data port priority, with an IF starvation guard. Stages stall while their req is high without gnt.
// PARAMETERS
//  AW          10  word-address width (1024-word memory)
//  DW          32  data width
//  MEM_LAT     1   memory read latency in cycles, legal 1..4 (mem_rdata valid MEM_LAT cycles after mem_en)
//  STARVE_MAX  4   consecutive IF losses while requesting before IF is forced to win, legal 1..15
// PORTS
//  clk        in   1   clock, all logic rising-edge
//  rst_n      in   1   asynchronous active-low reset
//  if_req     in   1   IF read request; held with if_addr stable until if_gnt
//  if_addr    in   AW  IF word address
//  if_gnt     out  1   one-cycle grant pulse to IF
//  if_rvalid  out  1   one-cycle pulse: if_rdata valid
//  if_rdata   out  DW  IF read data
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata stable until d_gnt
//  d_we       in   1   1=store, 0=load
//  d_addr     in   AW  data word address
//  d_wdata    in   DW  store data
//  d_gnt      out  1   one-cycle grant pulse to data port
//  d_rvalid   out  1   one-cycle pulse: d_rdata valid (loads only)
//  d_rdata    out  DW  load data
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write enable (qualified by mem_en)
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, starvation count=0, last-winner=IF. Reset mid-transaction aborts it: no rvalid, no write.
//  FSM: IDLE -> ACCESS -> (read: WAIT -> RESP) / (write: IDLE).
//   IDLE: if any req, arbitrate, register winner + command; next state ACCESS. No req: stay.
//   ACCESS (1 cycle): mem_en=1, mem_we/addr/wdata from winner; winner's gnt=1 this cycle only.
//     Store -> IDLE. Load -> WAIT if MEM_LAT>1 else RESP.
//   WAIT: count MEM_LAT-1 cycles, then RESP.
//   RESP (1 cycle): capture mem_rdata into winner's rdata, pulse winner's rvalid; -> IDLE.
//  Latency: req seen in IDLE at cycle N -> gnt/mem_en at N+1 -> rvalid at N+1+MEM_LAT. Store done at N+1.
//  Throughput: read occupies MEM_LAT+2 cycles, write 2 cycles; no back-to-back overlap.
//  rdata registers hold last value until next rvalid to the same port.
//  Arbitration (default): both req -> data wins, unless starve count == STARVE_MAX, then IF wins.
//   Starve count: +1 when IF requests and loses; cleared when IF wins; saturates at STARVE_MAX.
//  Single req: always granted regardless of count.
//  Requester deasserting req before gnt: illegal; arbiter samples only in IDLE, behaviour undefined for dropped reqs.
//  req still high the cycle after gnt = new request, arbitrated next IDLE.
//  gnt never asserted to both ports in one cycle; rvalid only to the port that was granted.
// CONFIGURATION
//  MEMARB_RR_EN defined: pure round-robin; on contention the port not granted last wins; starvation counter removed.
//  MEMARB_RR_EN undefined: data priority + STARVE_MAX guard as above.
// TESTING
//  1. Reset: rst_n=0 mid-WAIT of IF read -> all outputs 0, no if_rvalid after release, busy=0.
//  2. IF read alone, MEM_LAT=1, if_addr=5, mem[5]=32'h2800_0001 -> if_gnt 1 cycle after req, if_rvalid+rdata 1 cycle later.
//  3. Store d_addr=10, d_wdata=32'hDEAD_BEEF -> mem_en=mem_we=1 one cycle, d_gnt pulse, no d_rvalid, mem[10] updated; IDLE next.
//  4. Both req continuously, STARVE_MAX=4, default -> grant order D,D,D,D,IF,D,D,D,D,IF.
//  5. Same stimulus with MEMARB_RR_EN -> IF,D,IF,D alternation (last-winner reset=IF, so D first: D,IF,D,IF).
//  6. MEM_LAT=3 load d_addr=7 -> d_gnt at N+1, d_rvalid at N+4 with mem[7]; busy high N+1..N+4.

Source files
------------

// File: rtl/mips_mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the MIPS32 IF port and the MEM-stage data port.
// Build option MEMARB_RR_EN: round-robin on contention instead of data priority with an IF starvation guard.
module mips_mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    // WAIT covers MEM_LAT-1 cycles, counted down to zero.
    localparam logic [1:0] LAT_LOAD = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_e        state_q, state_d;
    logic          dwin_q, dwin_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    lat_q, lat_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          pick_d;

`ifdef MEMARB_RR_EN
    logic last_d_q, last_d_d;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;
`endif

    always_comb begin
        pick_d = d_req;
`ifdef MEMARB_RR_EN
        if (if_req && d_req) begin
            pick_d = !last_d_q;
        end
`else
        if (if_req && d_req) begin
            pick_d = (starve_q != STARVE_LIM);
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        dwin_d     = dwin_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEMARB_RR_EN
        last_d_d   = last_d_q;
`else
        starve_d   = starve_q;
`endif
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    dwin_d  = pick_d;
                    we_d    = pick_d && d_we;
                    addr_d  = pick_d ? d_addr : if_addr;
                    wdata_d = pick_d ? d_wdata : '0;
                    state_d = S_ACCESS;
`ifdef MEMARB_RR_EN
                    last_d_d = pick_d;
`else
                    if (if_req) begin
                        if (!pick_d) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
`endif
                end
            end
            S_ACCESS: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if_gnt    = !dwin_q;
                d_gnt     = dwin_q;
                if (we_q) begin
                    state_d = S_IDLE;
                end else if (MEM_LAT > 1) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_LOAD;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (lat_q == 2'd0) begin
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_RESP: begin
                busy    = 1'b1;
                state_d = S_IDLE;
                if (dwin_q) begin
                    d_rvalid  = 1'b1;
                    d_rdata_d = mem_rdata;
                end else begin
                    if_rvalid  = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data is forwarded in the RESP cycle and held afterwards.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dwin_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEMARB_RR_EN
            last_d_q   <= 1'b0;
`else
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dwin_q     <= dwin_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEMARB_RR_EN
            last_d_q   <= last_d_d;
`else
            starve_q   <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Bench for mips_mem_port_arbiter: two instances (MEM_LAT 1 and 3) against a transaction-timing model.
// Honours MEMARB_RR_EN for the arbitration rule of the model.
module tb_mips_mem_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    typedef struct packed {
        logic          ig;
        logic          dg;
        logic          irv;
        logic          drv;
        logic          en;
        logic          we;
        logic          busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } ev_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic          clk;
    logic          rst_n;
    logic          if_req    [2];
    logic [AW-1:0] if_addr   [2];
    logic          if_gnt    [2];
    logic          if_rvalid [2];
    logic [DW-1:0] if_rdata  [2];
    logic          d_req     [2];
    logic          d_we      [2];
    logic [AW-1:0] d_addr    [2];
    logic [DW-1:0] d_wdata   [2];
    logic          d_gnt     [2];
    logic          d_rvalid  [2];
    logic [DW-1:0] d_rdata   [2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          busy      [2];

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 5) return 32'h2800_0001;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem  [1024];
        logic [DW-1:0] pipe [LAT];

        mips_mem_port_arbiter #(
            .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[g]), .if_addr(if_addr[g]),
            .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]),
            .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]),
            .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        end

        // Memory with MEM_LAT read latency; garbage when no read was issued.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hBAD0_BAD0;
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end

        assign mem_rdata[g] = pipe[LAT-1];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    ev_t           ring    [2][8];
    logic [DW-1:0] ref_mem [2][1024];
    int            free_c  [2];
    int            starve  [2];
    bit            last_d  [2];
    logic [DW-1:0] hold_i  [2];
    logic [DW-1:0] hold_d  [2];
    bit            pend_i  [2];
    bit            pend_d  [2];
    int            ip      [2];
    int            dp      [2];
    int            ig_at   [2];
    int            dg_at   [2];
    bit            random_en;
    bit            saw_ig1;
    logic [AW-1:0] i_scr [$];
    cmd_t          d_scr [$];
    int            order [$];

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input int k);
        for (int s = 0; s < 8; s++) ring[k][s] = '0;
        free_c[k] = 0;
        starve[k] = 0;
        last_d[k] = 1'b0;
        hold_i[k] = '0;
        hold_d[k] = '0;
        pend_i[k] = 1'b0;
        pend_d[k] = 1'b0;
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
    endtask

    task automatic drive(input int k);
        if (!pend_i[k]) begin
            if (ip[k] < i_scr.size()) begin
                if_addr[k] = i_scr[ip[k]];
                ip[k]++;
                pend_i[k] = 1'b1;
            end else if (random_en && $urandom_range(0, 2) != 0) begin
                if_addr[k] = AW'($urandom_range(0, 63));
                pend_i[k] = 1'b1;
            end
            if_req[k] = pend_i[k];
        end
        if (!pend_d[k]) begin
            if (dp[k] < d_scr.size()) begin
                d_we[k]    = d_scr[dp[k]].we;
                d_addr[k]  = d_scr[dp[k]].addr;
                d_wdata[k] = d_scr[dp[k]].wdata;
                dp[k]++;
                pend_d[k] = 1'b1;
            end else if (random_en && $urandom_range(0, 2) != 0) begin
                d_we[k]    = 1'($urandom_range(0, 1));
                d_addr[k]  = AW'($urandom_range(0, 63));
                d_wdata[k] = $urandom;
                pend_d[k] = 1'b1;
            end
            d_req[k] = pend_d[k];
        end
    endtask

    // Transaction seen in an idle cycle t: grant at t+1, read data at t+1+LAT.
    task automatic arbitrate(input int k);
        bit            wd;
        bit            we;
        logic [AW-1:0] a;
        int            lat;
        int            s;
        lat = lat_of(k);
        if (free_c[k] > cyc || !(if_req[k] || d_req[k])) return;
`ifdef MEMARB_RR_EN
        if (if_req[k] && d_req[k]) wd = !last_d[k];
        else wd = d_req[k];
        last_d[k] = wd;
`else
        if (if_req[k] && d_req[k]) begin
            if (starve[k] == SMAX) begin
                wd = 1'b0;
            end else begin
                wd = 1'b1;
                starve[k]++;
            end
        end else begin
            wd = d_req[k];
        end
        if (!wd) starve[k] = 0;
`endif
        we = wd && d_we[k];
        a  = wd ? d_addr[k] : if_addr[k];
        s  = (cyc + 1) % 8;
        ring[k][s].ig    = !wd;
        ring[k][s].dg    = wd;
        ring[k][s].en    = 1'b1;
        ring[k][s].we    = we;
        ring[k][s].busy  = 1'b1;
        ring[k][s].addr  = a;
        ring[k][s].wdata = d_wdata[k];
        if (we) begin
            ref_mem[k][a] = d_wdata[k];
            free_c[k] = cyc + 2;
        end else begin
            for (int j = 1; j <= lat; j++) ring[k][(cyc + 1 + j) % 8].busy = 1'b1;
            s = (cyc + 1 + lat) % 8;
            ring[k][s].irv   = !wd;
            ring[k][s].drv   = wd;
            ring[k][s].rdata = ref_mem[k][a];
            free_c[k] = cyc + 2 + lat;
        end
    endtask

    task automatic tick();
        ev_t   e;
        string x;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            x = (k == 0) ? ".L1" : ".L3";
            if (!rst_n) begin
                check({"rst_busy", x}, 32'(busy[k]), 0);
                check({"rst_gnt", x}, 32'({if_gnt[k], d_gnt[k]}), 0);
                check({"rst_rvalid", x}, 32'({if_rvalid[k], d_rvalid[k]}), 0);
                check({"rst_mem", x}, 32'({mem_en[k], mem_we[k]}), 0);
                check({"rst_memaddr", x}, 32'(mem_addr[k]), 0);
                check({"rst_if_rdata", x}, if_rdata[k], 0);
                check({"rst_d_rdata", x}, d_rdata[k], 0);
                model_reset(k);
            end else begin
                e = ring[k][cyc % 8];
                ring[k][cyc % 8] = '0;
                if (e.irv) hold_i[k] = e.rdata;
                if (e.drv) hold_d[k] = e.rdata;
                check({"if_gnt", x}, 32'(if_gnt[k]), 32'(e.ig));
                check({"d_gnt", x}, 32'(d_gnt[k]), 32'(e.dg));
                check({"if_rvalid", x}, 32'(if_rvalid[k]), 32'(e.irv));
                check({"d_rvalid", x}, 32'(d_rvalid[k]), 32'(e.drv));
                check({"mem_en", x}, 32'(mem_en[k]), 32'(e.en));
                check({"busy", x}, 32'(busy[k]), 32'(e.busy));
                check({"if_rdata", x}, if_rdata[k], hold_i[k]);
                check({"d_rdata", x}, d_rdata[k], hold_d[k]);
                if (e.en) begin
                    check({"mem_we", x}, 32'(mem_we[k]), 32'(e.we));
                    check({"mem_addr", x}, 32'(mem_addr[k]), 32'(e.addr));
                    if (e.we) check({"mem_wdata", x}, mem_wdata[k], e.wdata);
                end
                if (if_gnt[k]) ig_at[k] = cyc;
                if (d_gnt[k]) dg_at[k] = cyc;
                if (if_rvalid[k]) check({"if_lat", x}, 32'(cyc - ig_at[k]), 32'(lat_of(k)));
                if (d_rvalid[k]) check({"d_lat", x}, 32'(cyc - dg_at[k]), 32'(lat_of(k)));
                if (k == 0 && if_gnt[0]) order.push_back(0);
                if (k == 0 && d_gnt[0]) order.push_back(1);
                if (k == 1 && if_gnt[1]) saw_ig1 = 1'b1;
                if (if_gnt[k]) pend_i[k] = 1'b0;
                if (d_gnt[k]) pend_d[k] = 1'b0;
                drive(k);
                arbitrate(k);
            end
        end
        cyc++;
    endtask

    function automatic bit all_done();
        for (int k = 0; k < 2; k++) begin
            if (ip[k] < i_scr.size() || dp[k] < d_scr.size()) return 1'b0;
            if (pend_i[k] || pend_d[k] || free_c[k] > cyc) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            if (all_done()) return;
            tick();
        end
        check("drain_timeout", 32'(all_done()), 1);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic cmd_t mk(input bit we, input int a, input logic [DW-1:0] w);
        cmd_t c;
        c.we    = we;
        c.addr  = AW'(a);
        c.wdata = w;
        return c;
    endfunction

    initial begin
        int exp_o;
        rst_n = 1'b1;
        random_en = 1'b0;
        saw_ig1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
            model_reset(k);
            if_addr[k] = '0;
            d_we[k]    = 1'b0;
            d_addr[k]  = '0;
            d_wdata[k] = '0;
            ip[k] = 0;
            dp[k] = 0;
            ig_at[k] = 0;
            dg_at[k] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // IF read aborted by reset while the 3-cycle instance waits on memory
        i_scr.push_back(AW'(5));
        for (int i = 0; i < 20 && !saw_ig1; i++) tick();
        check("ig1_seen", 32'(saw_ig1), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) tick();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) tick();

        i_scr.push_back(AW'(5));
        wait_done(40);
        check("if5_data.L1", if_rdata[0], 32'h2800_0001);
        check("if5_data.L3", if_rdata[1], 32'h2800_0001);

        d_scr.push_back(mk(1'b1, 10, 32'hDEAD_BEEF));
        wait_done(40);
        d_scr.push_back(mk(1'b0, 10, 32'h0));
        wait_done(40);
        check("ld10.L1", d_rdata[0], 32'hDEAD_BEEF);
        check("ld10.L3", d_rdata[1], 32'hDEAD_BEEF);
        d_scr.push_back(mk(1'b0, 7, 32'h0));
        wait_done(40);
        check("ld7.L1", d_rdata[0], init_word(7));
        check("ld7.L3", d_rdata[1], init_word(7));

        // Continuous contention from a fresh reset
        reset_pulse();
        order.delete();
        for (int i = 0; i < 12; i++) begin
            i_scr.push_back(AW'(i));
            d_scr.push_back(mk(i[0], 32 + i, $urandom));
        end
        for (int i = 0; i < 200 && order.size() < 10; i++) tick();
        check("order_len", 32'(order.size() >= 10), 1);
        for (int i = 0; i < 10 && i < order.size(); i++) begin
`ifdef MEMARB_RR_EN
            exp_o = (i % 2 == 0) ? 1 : 0;
`else
            exp_o = (i % 5 == 4) ? 0 : 1;
`endif
            check("grant_order", 32'(order[i]), 32'(exp_o));
        end
        wait_done(200);

        random_en = 1'b1;
        repeat (3000) tick();
        random_en = 1'b0;
        wait_done(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
